// File: rtl/fib_lab_pkg.sv
// Shared types and constants for the Fibonacci lab run controller:
// FSM states, failure codes, bus-owner select and the checked address map.
package fib_lab_pkg;

    localparam int N_F   = 7;
    localparam int N_SUM = 6;

    localparam logic [7:0] F_BASE   = 8'hF8;
    localparam logic [7:0] F_LAST   = F_BASE + 8'(N_F - 1);
    localparam logic [7:0] SUM_ADDR = 8'hF3;
    localparam logic [2:0] SUM_DONE = 3'(N_SUM);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PASS,
        FAIL
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_BADVAL  = 2'd1,
        FC_ORDER   = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LOADER,
        OWN_CPU
    } owner_e;

endpackage

// File: rtl/fib_bus_mux.sv
// Memory write-port multiplexer: forwards the current owner's address, data and
// strobe; the non-owner's strobe is simply dropped.
module fib_bus_mux
    import fib_lab_pkg::*;
(
    input  owner_e     owner_i,
    input  logic [7:0] ld_addr_i,
    input  logic [7:0] ld_data_i,
    input  logic       ld_wr_i,
    input  logic [7:0] cpu_addr_i,
    input  logic [7:0] cpu_data_i,
    input  logic       cpu_wr_i,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_data_o,
    output logic       mem_wr_o
);

    always_comb begin
        // NOTE: every output is defaulted before the case so no path can infer a latch.
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_wr_o   = 1'b0;
        case (owner_i)
            OWN_LOADER: begin
                mem_addr_o = ld_addr_i;
                mem_data_o = ld_data_i;
                mem_wr_o   = ld_wr_i;
            end
            OWN_CPU: begin
                mem_addr_o = cpu_addr_i;
                mem_data_o = cpu_data_i;
                mem_wr_o   = cpu_wr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fib_run_sequencer.sv
// Run controller for the Fibonacci lab: hands the memory port to the loader,
// then the CPU, and scores the CPU's writes as PASS or FAIL.
module fib_run_sequencer
    import fib_lab_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       ld_addr,
    input  logic [7:0]       ld_data,
    input  logic             ld_wr,
    input  logic             ld_done,
    input  logic [7:0]       cpu_addr,
    input  logic [7:0]       cpu_data,
    input  logic             cpu_wr,
    input  logic [N_F-1:0]   F_chk,
    input  logic [N_SUM-1:0] sum_chk,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_data,
    output logic             mem_wr,
    output logic             ld_gnt,
    output logic             cpu_run,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [N_F-1:0]   f_seen,
    output logic [2:0]       sum_idx
);

    localparam int TIMER_W = 12;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [N_F-1:0]       f_seen_q, f_seen_d;
    logic [2:0]           sum_idx_q, sum_idx_d;
    fail_e                fail_code_q, fail_code_d;
    owner_e               owner;

    always_comb begin
        owner = OWN_NONE;
        case (state_q)
            LOAD:    owner = OWN_LOADER;
            RUN:     owner = OWN_CPU;
            default: owner = OWN_NONE;
        endcase
    end

    fib_bus_mux u_bus_mux (
        .owner_i    (owner),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .ld_wr_i    (ld_wr),
        .cpu_addr_i (cpu_addr),
        .cpu_data_i (cpu_data),
        .cpu_wr_i   (cpu_wr),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_data),
        .mem_wr_o   (mem_wr)
    );

    // Checker flags are zero-padded so out-of-range indices (sum_idx==N_SUM) read 0.
    logic [7:0]     f_chk_pad, sum_chk_pad;
    logic [2:0]     f_idx, sum_idx_upd;
    logic [N_F-1:0] f_seen_upd;
    logic           f_wr, sum_wr, sum_hit, bad_val, bad_order, run_done, timed_out;

    always_comb begin
        f_chk_pad   = {{(8 - N_F){1'b0}}, F_chk};
        sum_chk_pad = {{(8 - N_SUM){1'b0}}, sum_chk};
        f_idx       = mem_addr[2:0] - F_BASE[2:0];
        f_wr        = mem_wr && (mem_addr >= F_BASE) && (mem_addr <= F_LAST);
        sum_wr      = mem_wr && (mem_addr == SUM_ADDR);
        bad_val     = f_wr && !f_chk_pad[f_idx];
        sum_hit     = sum_wr && sum_chk_pad[sum_idx_q];
        bad_order   = sum_wr && !sum_hit;
        f_seen_upd  = f_seen_q | F_chk;
        sum_idx_upd = sum_idx_q + 3'(sum_hit);
        run_done    = (&f_seen_upd) && (sum_idx_upd == SUM_DONE);
        timed_out   = (timer_q == TIMER_LAST);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        f_seen_d    = f_seen_q;
        sum_idx_d   = sum_idx_q;
        fail_code_d = fail_code_q;
        case (state_q)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    state_d     = LOAD;
                    f_seen_d    = '0;
                    sum_idx_d   = '0;
                    fail_code_d = FC_NONE;
                end
            end
            LOAD: begin
                if (ld_done) begin
                    state_d   = RUN;
                    timer_d   = '0;
                    f_seen_d  = '0;
                    sum_idx_d = '0;
                end
            end
            RUN: begin
                timer_d   = timer_q + 1'b1;
                f_seen_d  = f_seen_upd;
                sum_idx_d = sum_idx_upd;
                if (bad_val) begin
                    state_d     = FAIL;
                    fail_code_d = FC_BADVAL;
                end else if (bad_order) begin
                    state_d     = FAIL;
                    fail_code_d = FC_ORDER;
                end else if (run_done) begin
                    state_d     = PASS;
                end else if (timed_out) begin
                    state_d     = FAIL;
                    fail_code_d = FC_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            f_seen_q    <= '0;
            sum_idx_q   <= '0;
            fail_code_q <= FC_NONE;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            f_seen_q    <= f_seen_d;
            sum_idx_q   <= sum_idx_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign ld_gnt    = (state_q == LOAD);
    assign cpu_run   = (state_q == RUN);
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign pass      = (state_q == PASS);
    assign fail      = (state_q == FAIL);
    assign fail_code = fail_code_q;
    assign f_seen    = f_seen_q;
    assign sum_idx   = sum_idx_q;

endmodule

// File: tb/tb_fib_run_sequencer.sv
// Bench for fib_run_sequencer: directed scenarios plus randomized CPU write
// scripts scored by a rule-level reference model of a run.
module tb_fib_run_sequencer;

    localparam int TO = 16;
    localparam logic [7:0] FIB_TBL [7] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0D};
    localparam logic [7:0] SUM_TBL [6] = '{8'h02, 8'h04, 8'h07, 8'h0C, 8'h14, 8'h21};

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk, rst_n, start;
    logic [7:0] ld_addr, ld_data, cpu_addr, cpu_data;
    logic       ld_wr, ld_done, cpu_wr;
    logic [6:0] f_chk;
    logic [5:0] sum_chk;
    logic [7:0] mem_addr, mem_data;
    logic       mem_wr, ld_gnt, cpu_run, busy, pass, fail;
    logic [1:0] fail_code;
    logic [6:0] f_seen;
    logic [2:0] sum_idx;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t script[$];

    fib_run_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_wr     (ld_wr),
        .ld_done   (ld_done),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_wr    (cpu_wr),
        .F_chk     (f_chk),
        .sum_chk   (sum_chk),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr    (mem_wr),
        .ld_gnt    (ld_gnt),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .pass      (pass),
        .fail      (fail),
        .fail_code (fail_code),
        .f_seen    (f_seen),
        .sum_idx   (sum_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for fib_checker: flags a write on the memory bus that carries the right value.
    always_comb begin
        f_chk   = '0;
        sum_chk = '0;
        if (mem_wr) begin
            for (int i = 0; i < 7; i++)
                if (mem_addr == 8'(8'hF8 + i) && mem_data == FIB_TBL[i]) f_chk[i] = 1'b1;
            for (int k = 0; k < 6; k++)
                if (mem_addr == 8'hF3 && mem_data == SUM_TBL[k]) sum_chk[k] = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t mk(input logic [7:0] addr, input logic [7:0] data);
        return '{wr: 1'b1, addr: addr, data: data};
    endfunction

    // Rule-level model: walk the write script cycle by cycle and decide the outcome.
    task automatic model_run(output int end_cyc, output logic [1:0] code,
                             output logic [6:0] seen, output int hits);
        wr_t w;
        int  idx;
        seen    = '0;
        hits    = 0;
        code    = 2'd0;
        end_cyc = TO - 1;
        for (int c = 0; c < TO; c++) begin
            w = (c < script.size()) ? script[c] : '0;
            if (w.wr && w.addr >= 8'hF8 && w.addr <= 8'hFE) begin
                idx = int'(w.addr) - 'hF8;
                if (w.data == FIB_TBL[idx]) seen[idx] = 1'b1;
                else begin code = 2'd1; end_cyc = c; return; end
            end else if (w.wr && w.addr == 8'hF3) begin
                if (hits < 6 && w.data == SUM_TBL[hits]) hits++;
                else begin code = 2'd2; end_cyc = c; return; end
            end
            if (seen == 7'h7F && hits == 6) begin code = 2'd0; end_cyc = c; return; end
            if (c == TO - 1) begin code = 2'd3; end_cyc = c; return; end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_prog(input string name);
        @(negedge clk);
        check({name, " ld_gnt"}, 32'(ld_gnt), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " cleared"}, {19'd0, pass, fail, fail_code, f_seen, sum_idx}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            ld_wr   = 1'b1;
            ld_addr = 8'(i);
            ld_data = 8'($urandom);
            @(negedge clk);
            check({name, " ld bus"}, {15'd0, mem_wr, mem_addr, mem_data}, {15'd1, ld_addr, ld_data});
            step();
        end
        ld_wr   = 1'b0;
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
    endtask

    task automatic run_script(input string name);
        int         end_cyc, hits;
        logic [1:0] code;
        logic [6:0] seen;
        model_run(end_cyc, code, seen, hits);
        do_start();
        load_prog(name);
        for (int c = 0; c <= end_cyc; c++) begin
            {cpu_wr, cpu_addr, cpu_data} = (c < script.size()) ? script[c] : 17'd0;
            @(negedge clk);
            check({name, " cpu_run"}, 32'(cpu_run), 32'd1);
            check({name, " cpu bus"}, {15'd0, mem_wr, mem_addr, mem_data},
                  cpu_wr ? {15'd1, cpu_addr, cpu_data} : {15'd0, mem_addr, mem_data});
            step();
        end
        cpu_wr = 1'b0;
        @(negedge clk);
        check({name, " pass"}, 32'(pass), 32'(code == 2'd0));
        check({name, " fail"}, 32'(fail), 32'(code != 2'd0));
        check({name, " fail_code"}, 32'(fail_code), 32'(code));
        check({name, " f_seen"}, 32'(f_seen), 32'(seen));
        check({name, " sum_idx"}, 32'(sum_idx), 32'(hits));
        check({name, " ended"}, {30'd0, cpu_run, busy}, 32'd0);
    endtask

    task automatic build_random();
        int  perm[7];
        int  fi, si, j, tmp, pos;
        wr_t e;
        script.delete();
        for (int i = 0; i < 7; i++) perm[i] = i;
        for (int i = 6; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        fi = 0;
        si = 0;
        while (fi < 7 || si < 6) begin
            if ($urandom_range(0, 15) == 0) script.push_back('0);
            if ($urandom_range(0, 15) == 0) script.push_back(mk(8'($urandom_range(0, 239)), 8'($urandom)));
            if (fi < 7 && (si == 6 || $urandom_range(0, 1) == 1)) begin
                script.push_back(mk(8'(8'hF8 + perm[fi]), FIB_TBL[perm[fi]]));
                fi++;
            end else begin
                script.push_back(mk(8'hF3, SUM_TBL[si]));
                si++;
            end
        end
        pos = int'($urandom_range(0, script.size() - 1));
        e   = script[pos];
        case ($urandom_range(0, 3))
            1: begin e.data = e.data ^ 8'(1 << $urandom_range(0, 7)); script[pos] = e; end
            2: script.insert(pos, mk(8'(8'hF8 + perm[0]), FIB_TBL[perm[0]]));
            3: if (e.addr == 8'hF3) begin e.data = SUM_TBL[$urandom_range(0, 5)]; script[pos] = e; end
            default: ;
        endcase
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        ld_addr = '0; ld_data = '0; ld_wr = 1'b0; ld_done = 1'b0;
        cpu_addr = '0; cpu_data = '0; cpu_wr = 1'b0;
        #12;
        check("reset outputs", {8'd0, mem_addr, mem_data, mem_wr, ld_gnt, cpu_run, busy},
              32'd0);
        check("reset flags", {19'd0, pass, fail, fail_code, f_seen, sum_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Full correct program, cells and checkpoints interleaved.
        script.delete();
        for (int i = 0; i < 7; i++) begin
            script.push_back(mk(8'(8'hF8 + i), FIB_TBL[i]));
            if (i >= 1) script.push_back(mk(8'hF3, SUM_TBL[i - 1]));
        end
        run_script("t1 full");
        check("t1 pass const", {23'd0, pass, f_seen, sum_idx}, {23'd1, 7'h7F, 3'd6});

        script.delete();
        script.push_back(mk(8'hFB, 8'h04));
        run_script("t2 badval");
        check("t2 code const", 32'(fail_code), 32'd1);

        script.delete();
        script.push_back(mk(8'hF3, 8'h02));
        script.push_back(mk(8'hF3, 8'h07));
        run_script("t3 order");
        check("t3 code const", {29'd0, fail_code, 1'b0} | 32'(sum_idx), 32'd5);

        script.delete();
        run_script("t4 timeout");
        check("t4 code const", 32'(fail_code), 32'd3);

        // Non-owner strobes are dropped; start during RUN is ignored.
        do_start();
        cpu_wr = 1'b1; cpu_addr = 8'hF8; cpu_data = 8'h01;
        @(negedge clk);
        check("t5 cpu in LOAD", {30'd0, mem_wr, ld_gnt}, 32'd1);
        step();
        cpu_wr = 1'b0; ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        ld_wr = 1'b1; ld_addr = 8'hF3; ld_data = 8'h02; start = 1'b1;
        @(negedge clk);
        check("t5 ld in RUN", {30'd0, mem_wr, cpu_run}, 32'd1);
        step();
        ld_wr = 1'b0; start = 1'b0;
        @(negedge clk);
        check("t5 start ignored", {28'd0, cpu_run, sum_idx}, {28'd1, 3'd0});
        for (int i = 0; i < TO + 4 && fail !== 1'b1; i++) step();
        check("t5 timeout", {29'd0, fail, fail_code}, {29'd1, 2'd3});

        // Reset mid-run clears outputs asynchronously.
        do_start();
        load_prog("t6 load");
        cpu_wr = 1'b1; cpu_addr = 8'hF8; cpu_data = 8'h01;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t6 async outputs", {8'd0, mem_addr, mem_data, mem_wr, ld_gnt, cpu_run, busy},
              32'd0);
        check("t6 async flags", {19'd0, pass, fail, fail_code, f_seen, sum_idx}, 32'd0);
        cpu_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_start();
        @(negedge clk);
        check("t6 restart", {30'd0, ld_gnt, busy}, 32'd3);
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        for (int i = 0; i < TO + 4 && fail !== 1'b1; i++) step();
        check("t6 run ended", 32'(fail_code), 32'd3);

        for (int r = 0; r < 40; r++) begin
            build_random();
            run_script($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
